// File: rtl/evolve_scheduler_pkg.sv
// Shared constants, FSM encoding and neighbour-offset tables for the Life scheduler.
// Contents: ADDR_WIDTH, MODE_EDIT, NBR_COUNT, state_t, DIR_* codes, off_x()/off_y().
// No ports; imported by evolve_scheduler and wrap_offset.
package evolve_scheduler_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam logic MODE_EDIT = 1'b1;
  localparam int NBR_COUNT = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_EVAL      = 3'd2,
    ST_WAIT_SWAP = 3'd3,
    ST_ED_RD     = 3'd4,
    ST_ED_WAIT   = 3'd5,
    ST_ED_WR     = 3'd6
  } state_t;

  // Two's-complement style step direction fed to wrap_offset.
  localparam logic [1:0] DIR_ZERO = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;

  // Read order: centre first, then the 8 neighbours row by row from the top-left.
  function automatic logic [1:0] off_x(input logic [3:0] k);
    case (k)
      4'd1, 4'd4, 4'd6: off_x = DIR_NEG;
      4'd3, 4'd5, 4'd8: off_x = DIR_POS;
      default:          off_x = DIR_ZERO;
    endcase
  endfunction

  function automatic logic [1:0] off_y(input logic [3:0] k);
    case (k)
      4'd1, 4'd2, 4'd3: off_y = DIR_NEG;
      4'd6, 4'd7, 4'd8: off_y = DIR_POS;
      default:          off_y = DIR_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/wrap_offset.sv
// Toroidal coordinate stepper: coord + dir wrapped into [0, LIMIT-1], no divider.
// Ports: coord (in), dir (in, DIR_NEG/DIR_ZERO/DIR_POS), result (out, combinational).
// Purely combinational, zero latency.
module wrap_offset
  import evolve_scheduler_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic [ADDR_WIDTH-1:0] coord,
  input  logic [1:0]            dir,
  output logic [ADDR_WIDTH-1:0] result
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LIMIT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  always_comb begin
    result = coord;
    case (dir)
      DIR_NEG: result = (coord == '0)   ? LAST : coord - ONE;
      DIR_POS: result = (coord == LAST) ? '0   : coord + ONE;
      default: result = coord;
    endcase
  end

endmodule

// File: rtl/evolve_scheduler.sv
// Life generation sequencer over a ping-pong 1-bit cell memory, plus edit-mode cursor toggle.
// Ports: clk/rst, mode/step_tick/frame_start/edit_toggle/cur_x/cur_y controls, mem_rd_* / mem_wr_*
// to the external cell memory, disp_bank, busy, overrun, generation status. 10 cycles per cell.
module evolve_scheduler
  import evolve_scheduler_pkg::*;
#(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8,
  parameter int GEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  step_tick,
  input  logic                  frame_start,
  input  logic                  edit_toggle,
  input  logic [ADDR_WIDTH-1:0] cur_x,
  input  logic [ADDR_WIDTH-1:0] cur_y,
  output logic [ADDR_WIDTH-1:0] mem_rd_x,
  output logic [ADDR_WIDTH-1:0] mem_rd_y,
  output logic                  mem_rd_bank,
  input  logic                  mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_x,
  output logic [ADDR_WIDTH-1:0] mem_wr_y,
  output logic                  mem_wr_bank,
  output logic                  mem_wr_data,
  output logic                  disp_bank,
  output logic                  busy,
  output logic                  overrun,
  output logic [GEN_W-1:0]      generation
);

  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(MAP_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(MAP_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
  localparam logic [3:0]            K_LAST = 4'(NBR_COUNT - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   x, y, ed_x, ed_y;
  logic [ADDR_WIDTH-1:0]   nb_x, nb_y;
  logic [3:0]              k, n, n_total;
  logic                    centre, ed_data, next_cell, last_cell, edit_mode;

  assign edit_mode = (mode == MODE_EDIT);
  // The k=8 datum lands in EVAL itself, so it is folded in combinationally.
  assign n_total   = n + {3'b000, mem_rd_data};
  assign next_cell = (n_total == 4'd3) | (centre & (n_total == 4'd2));
  assign last_cell = (x == X_LAST) && (y == Y_LAST);

  wrap_offset #(.LIMIT(MAP_WIDTH))  u_wrap_x (.coord(x), .dir(off_x(k)), .result(nb_x));
  wrap_offset #(.LIMIT(MAP_HEIGHT)) u_wrap_y (.coord(y), .dir(off_y(k)), .result(nb_y));

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!edit_mode && step_tick)      state_nxt = ST_RD;
        else if (edit_mode && edit_toggle) state_nxt = ST_ED_RD;
      end
      ST_RD: begin
        if (edit_mode)        state_nxt = ST_IDLE;
        else if (k == K_LAST) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (edit_mode)      state_nxt = ST_IDLE;
        else if (last_cell) state_nxt = ST_WAIT_SWAP;
        else                state_nxt = ST_RD;
      end
      ST_WAIT_SWAP: begin
        if (edit_mode || frame_start) state_nxt = ST_IDLE;
      end
      ST_ED_RD:   state_nxt = ST_ED_WAIT;
      ST_ED_WAIT: state_nxt = ST_ED_WR;
      ST_ED_WR:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    mem_rd_bank = disp_bank;
    mem_rd_x    = '0;
    mem_rd_y    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_x    = '0;
    mem_wr_y    = '0;
    mem_wr_bank = 1'b0;
    mem_wr_data = 1'b0;
    case (state)
      ST_RD: begin
        mem_rd_x = nb_x;
        mem_rd_y = nb_y;
      end
      ST_ED_RD: begin
        mem_rd_x = cur_x;
        mem_rd_y = cur_y;
      end
      ST_EVAL: begin
        mem_wr_en   = 1'b1;
        mem_wr_x    = x;
        mem_wr_y    = y;
        mem_wr_bank = ~disp_bank;
        mem_wr_data = next_cell;
      end
      ST_ED_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_x    = ed_x;
        mem_wr_y    = ed_y;
        mem_wr_bank = disp_bank;
        mem_wr_data = ~ed_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x          <= '0;
      y          <= '0;
      k          <= '0;
      n          <= '0;
      centre     <= 1'b0;
      ed_x       <= '0;
      ed_y       <= '0;
      ed_data    <= 1'b0;
      disp_bank  <= 1'b0;
      generation <= '0;
      overrun    <= 1'b0;
    end else begin
      if (step_tick && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!edit_mode && step_tick) begin
            x <= '0;
            y <= '0;
            k <= '0;
          end
        end
        ST_RD: begin
          k <= k + 4'd1;
          // Datum for read k arrives while k+1 is being issued.
          if (k == 4'd0)      n <= '0;
          else if (k == 4'd1) centre <= mem_rd_data;
          else                n <= n + {3'b000, mem_rd_data};
        end
        ST_EVAL: begin
          k <= '0;
          if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + ONE;
          end else begin
            x <= x + ONE;
          end
        end
        ST_WAIT_SWAP: begin
          if (!edit_mode && frame_start) begin
            disp_bank  <= ~disp_bank;
            generation <= generation + GEN_W'(1);
          end
        end
        ST_ED_RD: begin
          ed_x <= cur_x;
          ed_y <= cur_y;
        end
        ST_ED_WAIT: ed_data <= mem_rd_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_evolve_scheduler.sv
// Self-checking bench for evolve_scheduler: behavioural cell memory, Life reference model,
// and a write scoreboard fed when each generation/edit is launched.
// Ports: none (top-level bench).
module tb_evolve_scheduler;
  import evolve_scheduler_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int GW = 16;

  logic clk = 1'b0;
  logic rst, mode, step_tick, frame_start, edit_toggle;
  logic [ADDR_WIDTH-1:0] cur_x, cur_y;
  logic [ADDR_WIDTH-1:0] mem_rd_x, mem_rd_y, mem_wr_x, mem_wr_y;
  logic mem_rd_bank, mem_rd_data, mem_wr_en, mem_wr_bank, mem_wr_data;
  logic disp_bank, busy, overrun;
  logic [GW-1:0] generation;

  always #5 clk = ~clk;

  evolve_scheduler #(.MAP_WIDTH(W), .MAP_HEIGHT(H), .GEN_W(GW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .step_tick(step_tick), .frame_start(frame_start),
    .edit_toggle(edit_toggle), .cur_x(cur_x), .cur_y(cur_y),
    .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y), .mem_rd_bank(mem_rd_bank), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_x(mem_wr_x), .mem_wr_y(mem_wr_y), .mem_wr_bank(mem_wr_bank),
    .mem_wr_data(mem_wr_data), .disp_bank(disp_bank), .busy(busy), .overrun(overrun),
    .generation(generation)
  );

  typedef struct {
    int x;
    int y;
    bit bank;
    bit data;
  } wr_t;

  bit  mem [0:1][0:H-1][0:W-1];
  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  wr_count = 0;
  int  wr_cyc = 0;
  bit  exp_disp;
  int  exp_gen;

  always @(posedge clk) cyc <= cyc + 1;

  // Cell memory: registered read (1-cycle latency), write on strobe.
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_rd_bank][mem_rd_y[2:0]][mem_rd_x[2:0]];
    if (mem_wr_en) mem[mem_wr_bank][mem_wr_y[2:0]][mem_wr_x[2:0]] = mem_wr_data;
  end

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_count++;
      wr_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got x=%0d y=%0d bank=%0d data=%0d exp none",
                 mem_wr_x, mem_wr_y, mem_wr_bank, mem_wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (int'(mem_wr_x) !== e.x || int'(mem_wr_y) !== e.y ||
            mem_wr_bank !== e.bank || mem_wr_data !== e.data) begin
          errors++;
          $display("FAIL sb_write got x=%0d y=%0d bank=%0d data=%0d exp x=%0d y=%0d bank=%0d data=%0d",
                   mem_wr_x, mem_wr_y, mem_wr_bank, mem_wr_data, e.x, e.y, e.bank, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b0;
    repeat (ncyc) tick();
    rst = 1'b1;
    exp_disp = 1'b0;
    exp_gen = 0;
    sb.delete();
  endtask

  task automatic clear_mem();
    for (int b = 0; b < 2; b++)
      for (int yy = 0; yy < H; yy++)
        for (int xx = 0; xx < W; xx++)
          mem[b][yy][xx] = 1'b0;
  endtask

  function automatic bit ref_next(input bit b, input int xx, input int yy);
    int cnt = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0)
          cnt += int'(mem[b][(yy + dy + H) % H][(xx + dx + W) % W]);
    return (cnt == 3) || (mem[b][yy][xx] && cnt == 2);
  endfunction

  task automatic push_gen();
    wr_t e;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        e.x = xx;
        e.y = yy;
        e.bank = ~exp_disp;
        e.data = ref_next(exp_disp, xx, yy);
        sb.push_back(e);
      end
  endtask

  task automatic start_step();
    step_tick = 1'b1;
    tick();
    step_tick = 1'b0;
  endtask

  // Full generation: 640 busy cycles, then optional frame_start swap.
  task automatic run_gen(input bit do_swap, input bit fs_on_entry);
    int idle_cycles = 0;
    push_gen();
    start_step();
    checks++;
    if (mem_rd_x !== 8'd0 || mem_rd_y !== 8'd0) begin
      errors++;
      $display("FAIL first_read got (%0d,%0d) exp (0,0)", mem_rd_x, mem_rd_y);
    end
    if (!busy) idle_cycles++;
    tick();
    checks++;
    if (int'(mem_rd_x) !== W - 1 || int'(mem_rd_y) !== H - 1) begin
      errors++;
      $display("FAIL wrap_read got (%0d,%0d) exp (%0d,%0d)", mem_rd_x, mem_rd_y, W - 1, H - 1);
    end
    if (!busy) idle_cycles++;
    for (int i = 2; i < W * H * 10; i++) begin
      tick();
      if (!busy) idle_cycles++;
      if (i == W * H * 10 - 1 && fs_on_entry) frame_start = 1'b1;
    end
    checks++;
    if (mem_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL last_eval_strobe got %0b exp 1", mem_wr_en);
    end
    tick();
    frame_start = 1'b0;
    checks++;
    if (idle_cycles != 0 || busy !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL gen_busy got idle=%0d busy=%0b wr_en=%0b exp 0 1 0", idle_cycles, busy, mem_wr_en);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL gen_writes got %0d pending exp 0", sb.size());
    end
    checks++;
    if (disp_bank !== exp_disp) begin
      errors++;
      $display("FAIL swap_wait got %0b exp %0b", disp_bank, exp_disp);
    end
    if (do_swap) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      exp_disp = ~exp_disp;
      exp_gen++;
      checks++;
      if (disp_bank !== exp_disp || int'(generation) !== exp_gen || busy !== 1'b0) begin
        errors++;
        $display("FAIL swap got bank=%0b gen=%0d busy=%0b exp %0b %0d 0",
                 disp_bank, generation, busy, exp_disp, exp_gen);
      end
    end
  endtask

  task automatic test_reset();
    mode = MODE_EDIT;
    clear_mem();
    do_reset(2);
    checks++;
    if (busy !== 1'b0 || disp_bank !== 1'b0 || generation !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got busy=%0b bank=%0b gen=%0d ovr=%0b exp all 0",
               busy, disp_bank, generation, overrun);
    end
    checks++;
    if (mem_wr_en !== 1'b0 || mem_wr_x !== '0 || mem_wr_y !== '0 || mem_rd_x !== '0 ||
        mem_rd_y !== '0 || mem_wr_bank !== 1'b0 || mem_wr_data !== 1'b0 || mem_rd_bank !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_port got wr_en=%0b wr=(%0d,%0d) rd=(%0d,%0d) exp all 0",
               mem_wr_en, mem_wr_x, mem_wr_y, mem_rd_x, mem_rd_y);
    end
  endtask

  task automatic test_edit();
    wr_t e;
    for (int t = 0; t < 2; t++) begin
      int c0, n0;
      bit done = 1'b0;
      cur_x = 8'd3;
      cur_y = 8'd3;
      e.x = 3;
      e.y = 3;
      e.bank = 1'b0;
      e.data = (t == 0) ? 1'b1 : 1'b0;
      sb.push_back(e);
      n0 = wr_count;
      c0 = cyc;
      edit_toggle = 1'b1;
      tick();
      edit_toggle = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
        tick();
        if (wr_count != n0) done = 1'b1;
      end
      checks++;
      if (!done || wr_count - n0 != 1 || wr_cyc - c0 != 3) begin
        errors++;
        $display("FAIL edit_latency got writes=%0d latency=%0d exp 1 3", wr_count - n0, wr_cyc - c0);
      end
      repeat (3) tick();
      checks++;
      if (mem[0][3][3] !== e.data || busy !== 1'b0) begin
        errors++;
        $display("FAIL edit_cell got %0b busy=%0b exp %0b 0", mem[0][3][3], busy, e.data);
      end
    end
  endtask

  task automatic test_blinker();
    int bad = 0;
    mode = 1'b0;
    do_reset(1);
    clear_mem();
    mem[0][2][3] = 1'b1;
    mem[0][3][3] = 1'b1;
    mem[0][4][3] = 1'b1;
    run_gen(1'b1, 1'b1);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (mem[1][yy][xx] !== ((yy == 3) && (xx >= 2) && (xx <= 4))) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL blinker_bank1 got %0d wrong cells exp 0", bad);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    mode = 1'b0;
    do_reset(1);
    clear_mem();
    mem[0][0][7] = 1'b1;
    mem[0][0][0] = 1'b1;
    mem[0][0][1] = 1'b1;
    run_gen(1'b0, 1'b0);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (mem[1][yy][xx] !== ((xx == 0) && (yy == 7 || yy == 0 || yy == 1))) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_bank1 got %0d wrong cells exp 0", bad);
    end
  endtask

  task automatic test_still_life();
    mode = 1'b0;
    do_reset(1);
    clear_mem();
    mem[0][0][0] = 1'b1;
    mem[0][0][1] = 1'b1;
    mem[0][1][0] = 1'b1;
    mem[0][1][1] = 1'b1;
    for (int g = 0; g < 3; g++) begin
      int bad = 0;
      run_gen(1'b1, 1'b0);
      for (int yy = 0; yy < H; yy++)
        for (int xx = 0; xx < W; xx++)
          if (mem[exp_disp][yy][xx] !== mem[~exp_disp][yy][xx] ||
              mem[exp_disp][yy][xx] !== ((xx < 2) && (yy < 2))) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL still_life gen %0d got %0d wrong cells exp 0", g + 1, bad);
      end
    end
    checks++;
    if (generation !== 16'd3) begin
      errors++;
      $display("FAIL still_gen got %0d exp 3", generation);
    end
  endtask

  task automatic test_overrun_abort();
    mode = 1'b0;
    do_reset(1);
    clear_mem();
    mem[0][2][3] = 1'b1;
    mem[0][3][3] = 1'b1;
    mem[0][4][3] = 1'b1;
    push_gen();
    start_step();
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 100) step_tick = 1'b1;
      if (i == 101) begin
        step_tick = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL overrun got ovr=%0b busy=%0b exp 1 1", overrun, busy);
        end
      end
      if (i == 300) mode = MODE_EDIT;
    end
    tick();
    checks++;
    if (busy !== 1'b0 || disp_bank !== exp_disp || int'(generation) !== exp_gen) begin
      errors++;
      $display("FAIL abort got busy=%0b bank=%0b gen=%0d exp 0 %0b %0d", busy, disp_bank, generation,
               exp_disp, exp_gen);
    end
    checks++;
    if (sb.size() != W * H - 30) begin
      errors++;
      $display("FAIL abort_writes got %0d pending exp %0d", sb.size(), W * H - 30);
    end
    sb.delete();
    mode = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++;
    if (disp_bank !== exp_disp || int'(generation) !== exp_gen || busy !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL abort_noswap got bank=%0b gen=%0d busy=%0b ovr=%0b exp %0b %0d 0 1",
               disp_bank, generation, busy, overrun, exp_disp, exp_gen);
    end
  endtask

  task automatic test_reset_midop();
    int n0;
    mode = 1'b0;
    do_reset(1);
    clear_mem();
    mem[0][2][3] = 1'b1;
    mem[0][3][3] = 1'b1;
    mem[0][4][3] = 1'b1;
    push_gen();
    start_step();
    step_tick = 1'b1;
    tick();
    step_tick = 1'b0;
    for (int i = 2; i <= 200; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (busy !== 1'b0 || disp_bank !== 1'b0 || overrun !== 1'b0 || generation !== '0) begin
      errors++;
      $display("FAIL midop_reset got busy=%0b bank=%0b ovr=%0b gen=%0d exp 0 0 0 0",
               busy, disp_bank, overrun, generation);
    end
    checks++;
    if (sb.size() != W * H - 20) begin
      errors++;
      $display("FAIL midop_writes got %0d pending exp %0d", sb.size(), W * H - 20);
    end
    sb.delete();
    n0 = wr_count;
    repeat (20) tick();
    checks++;
    if (wr_count != n0) begin
      errors++;
      $display("FAIL midop_quiet got %0d writes exp 0", wr_count - n0);
    end
    run_gen(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    mode = MODE_EDIT;
    step_tick = 1'b0;
    frame_start = 1'b0;
    edit_toggle = 1'b0;
    cur_x = '0;
    cur_y = '0;
    exp_disp = 1'b0;
    exp_gen = 0;
    test_reset();
    test_edit();
    test_blinker();
    test_wrap();
    test_still_life();
    test_overrun_abort();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
